// File: rtl/i2c_temp_target.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_temp_target
//  Purpose  : I2C target answering at a 7-bit address with a small
//             sensor-style register map (temperature word, configuration
//             register, read-only ID). Register pointer auto-increments.
//             SCL/SDA are oversampled on clk (clk >= 8x SCL).
//  Ports    : clk   - system clock
//             reset - synchronous, active-high reset
//             scl   - I2C clock from the master
//             sda   - I2C data, driven only low or released (high-Z)
//             temp  - live temperature word {MSB, LSB}
//             cfg   - configuration register (register 0x03)
//             busy  - high from START until STOP or abort
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_temp_target #(
   parameter logic [6:0] ADDR     = 7'h4B,
   parameter logic [7:0] ID_VALUE = 8'hCB
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl,
   inout  wire         sda,
   input  logic [15:0] temp,
   output logic [7:0]  cfg,
   output logic        busy
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_ADDR     = 4'd1;
   localparam logic [3:0] S_ACK_ADDR = 4'd2;
   localparam logic [3:0] S_WR_PTR   = 4'd3;
   localparam logic [3:0] S_ACK_PTR  = 4'd4;
   localparam logic [3:0] S_WR_DATA  = 4'd5;
   localparam logic [3:0] S_ACK_DATA = 4'd6;
   localparam logic [3:0] S_RD_DATA  = 4'd7;
   localparam logic [3:0] S_RD_ACK   = 4'd8;
   localparam logic [3:0] S_IGNORE   = 4'd9;

   logic       scl_s1_q, scl_s2_q, scl_prev_q;
   logic       sda_s1_q, sda_s2_q, sda_prev_q;
   logic [3:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] cfg_q, cfg_d;
   logic [15:0] snap_q, snap_d;
   logic       rw_q, rw_d;
   logic       oe_q, oe_d;
   logic       busy_q, busy_d;

   logic       start_det, stop_det, scl_rise, scl_fall;
   logic [7:0] byte_in;
   logic [7:0] rd_byte;

   // Bus conditions seen on the synchronized lines
   assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
   assign scl_rise  = scl_s2_q & ~scl_prev_q;
   assign scl_fall  = ~scl_s2_q & scl_prev_q;
   // Byte as it will look once the bit on this rising edge is shifted in
   assign byte_in   = {shift_q[6:0], sda_s2_q};

   always_comb begin
      rd_byte = 8'h00;
      case (ptr_q)
         8'h00:   rd_byte = snap_q[15:8];
         8'h01:   rd_byte = snap_q[7:0];
         8'h03:   rd_byte = cfg_q;
         8'h0B:   rd_byte = ID_VALUE;
         default: rd_byte = 8'h00;
      endcase
   end

   // State and data registers
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_s1_q   <= 1'b1;
         scl_s2_q   <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= S_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         ptr_q      <= 8'h00;
         cfg_q      <= 8'h00;
         snap_q     <= 16'h0000;
         rw_q       <= 1'b0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         scl_s1_q   <= scl;
         scl_s2_q   <= scl_s1_q;
         scl_prev_q <= scl_s2_q;
         sda_s1_q   <= sda;
         sda_s2_q   <= sda_s1_q;
         sda_prev_q <= sda_s2_q;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         cfg_q      <= cfg_d;
         snap_q     <= snap_d;
         rw_q       <= rw_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state logic. In the ACK states bit_cnt marks that the 9th
   // rising edge has been seen, so the following fall ends the ACK slot.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      if (stop_det) begin
         state_d   = S_IDLE;
         bit_cnt_d = 3'd0;
      end else if (start_det) begin
         state_d   = S_ADDR;
         bit_cnt_d = 3'd0;
      end else begin
         case (state_q)
            S_ADDR, S_WR_PTR, S_WR_DATA, S_RD_DATA: begin
               if (scl_rise) begin
                  if (bit_cnt_q == 3'd7) begin
                     bit_cnt_d = 3'd0;
                     case (state_q)
                        S_ADDR:    state_d = (byte_in[7:1] == ADDR) ? S_ACK_ADDR : S_IGNORE;
                        S_WR_PTR:  state_d = S_ACK_PTR;
                        S_WR_DATA: state_d = S_ACK_DATA;
                        default:   state_d = S_RD_ACK;
                     endcase
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            S_ACK_ADDR, S_ACK_PTR, S_ACK_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = 3'd1;
               end else if (scl_fall && bit_cnt_q == 3'd1) begin
                  bit_cnt_d = 3'd0;
                  if (state_q == S_ACK_ADDR)
                     state_d = rw_q ? S_RD_DATA : S_WR_PTR;
                  else
                     state_d = S_WR_DATA;
               end
            end
            S_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_s2_q) state_d   = S_IGNORE;
                  else          bit_cnt_d = 3'd1;
               end else if (scl_fall && bit_cnt_q == 3'd1) begin
                  bit_cnt_d = 3'd0;
                  state_d   = S_RD_DATA;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and SDA drive. SDA only changes on SCL falls; entering
   // RD_DATA loads the byte and presents its MSB on that same fall.
   always_comb begin
      shift_d = shift_q;
      ptr_d   = ptr_q;
      cfg_d   = cfg_q;
      snap_d  = snap_q;
      rw_d    = rw_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      if (start_det)     busy_d = 1'b1;
      else if (stop_det) busy_d = 1'b0;
      if (start_det || stop_det) begin
         oe_d = 1'b0;
      end else begin
         case (state_q)
            S_ADDR: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  if (bit_cnt_q == 3'd7) begin
                     rw_d = sda_s2_q;
                     if (byte_in[7:1] == ADDR && sda_s2_q) snap_d = temp;
                  end
               end
            end
            S_WR_PTR: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  if (bit_cnt_q == 3'd7) ptr_d = byte_in;
               end
            end
            S_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  if (bit_cnt_q == 3'd7) begin
                     if (ptr_q == 8'h03) cfg_d = byte_in;
                     ptr_d = ptr_q + 8'd1;
                  end
               end
            end
            S_ACK_ADDR, S_ACK_PTR, S_ACK_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     oe_d = 1'b1;
                  end else if (state_q == S_ACK_ADDR && rw_q) begin
                     shift_d = rd_byte;
                     oe_d    = ~rd_byte[7];
                  end else begin
                     oe_d = 1'b0;
                  end
               end
            end
            S_RD_DATA: begin
               if (scl_rise && bit_cnt_q == 3'd7) begin
                  ptr_d = ptr_q + 8'd1;
               end else if (scl_fall) begin
                  shift_d = {shift_q[6:0], shift_q[7]};
                  oe_d    = ~shift_q[6];
               end
            end
            S_RD_ACK: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     oe_d = 1'b0;
                  end else begin
                     shift_d = rd_byte;
                     oe_d    = ~rd_byte[7];
                  end
               end
            end
            default: oe_d = 1'b0;
         endcase
      end
   end

   assign sda  = oe_q ? 1'b0 : 1'bz;
   assign cfg  = cfg_q;
   assign busy = busy_q;

endmodule
`default_nettype wire
